fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
- F-stage program counter and next-PC selector for the 5-stage MIPS pipeline with delayed branches.
- Consumes the D-stage branch decision (compare condition) plus D-stage jump decode. Holds and advances the fetch PC.
- Redirects to the CP0 exception entry on req and to EPC on eret.
- Produces the F-stage delay-slot flag and the fetch address-error flag, both consumed by the F/D pipeline register and CP0.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- EXC_ENTRY, 32'h0000_4180, exception handler entry address.
- IM_BASE, 32'h0000_3000, lowest legal fetch address.
- IM_LIMIT, 32'h0000_6FFC, highest legal fetch address.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  hazard-unit freeze of F and D.
- req  in  1  CP0 exception/interrupt request (flush, go to EXC_ENTRY).
- eret  in  1  eret resolved in D.
- epc  in  32  CP0 EPC value.
- D_pc  in  32  PC of the instruction in D.
- D_is_branch  in  1  D holds beq/bne/bgezal.
- D_cond  in  1  branch condition from the D-stage compare unit.
- D_is_j  in  1  D holds j/jal.
- D_instr_index  in  26  instr[25:0] of D.
- D_imm16  in  16  instr[15:0] of D.
- D_is_jr  in  1  D holds jr/jalr.
- D_rs_val  in  32  forwarded rs value in D.
- F_pc  out  32  current fetch address.
- F_bd  out  1  instruction in F is a delay-slot instruction.
- F_exc_adel  out  1  fetch address error.
- redirect_cnt  out  16  saturating count of taken control transfers.

Behaviour:
- Reset: asynchronous on reset==0.
  - F_pc=RESET_PC, F_bd=0, redirect_cnt=0.
  - F_exc_adel follows F_pc, so it is 0 for the default RESET_PC.
  - Reset overrides everything, including mid-stall or mid-redirect.
- Next-PC selection on each rising edge, first match wins:
  1. req: F_pc<=EXC_ENTRY, F_bd<=0.
  2. eret: F_pc<=epc, F_bd<=0. The eret delay slot is not executed.
  3. stall: F_pc and F_bd hold. redirect_cnt holds.
  4. D_is_jr: F_pc<=D_rs_val.
  5. D_is_j: F_pc<={D_pc4[31:28], D_instr_index, 2'b00}, where D_pc4=D_pc+4.
  6. D_is_branch && D_cond: F_pc<=D_pc+4+(sext(D_imm16)<<2).
  7. Otherwise: F_pc<=F_pc+4.
- All address arithmetic is 32-bit modulo 2^32. Wrap-around is not trapped here; it is caught by F_exc_adel.
- Rows 4–7 imply delayed-branch semantics. The instruction already fetched when D resolves (F_pc at that edge, i.e. D_pc+4) is the delay slot and executes.
- F_bd: on a non-stall, non-req, non-eret edge, F_bd<=(D_is_branch|D_is_j|D_is_jr).
  - The flag is set regardless of whether the branch is taken.
- redirect_cnt: increments on an edge where row 4, 5 or 6 fires, and also on req and eret edges. It saturates at 16'hFFFF.
- F_exc_adel is combinational from F_pc: (F_pc[1:0]!=0) | (F_pc<IM_BASE) | (F_pc>IM_LIMIT), with unsigned compares.
- Simultaneous events:
  - req with eret: req wins.
  - req with stall: req wins, and the stall is ignored for this unit.
  - Branch taken with stall: hold. D re-evaluates the branch next cycle with fresh forwarded data.
  - More than one of D_is_j/D_is_jr/D_is_branch asserted is illegal input. Priority order still applies deterministically.
- Latency: a redirect is visible on F_pc one cycle after the D-stage decision. There is no bubble beyond the architectural delay slot.

Decomposition:
- The shared macro/package holds RESET_PC, EXC_ENTRY, IM_BASE and IM_LIMIT defaults, shared with CP0 and the instruction memory.
- npc_calc is the natural combinational sub-module: it computes the branch, jump and sequential targets from D_pc, the immediates and F_pc.
- fetch_pc_unit keeps the registers, priority mux, F_bd and counter.

Test Plan:
- Reset release with no stimulus for 3 cycles -> F_pc = 0x3000, 0x3004, 0x3008, 0x300C; F_bd=0; F_exc_adel=0.
- D_pc=0x3008, D_is_branch=1, D_cond=1, D_imm16=16'hFFFE -> next F_pc=0x3004. The same edge sets F_bd=1. redirect_cnt increments by 1.
- D_is_branch=1, D_cond=0 at D_pc=0x3010 -> F_pc=F_pc+4 and F_bd=1. A further 2-cycle stall holds F_pc and F_bd unchanged.
- D_is_jr=1, D_rs_val=0x3001 -> F_pc=0x3001 and F_exc_adel=1. With D_rs_val=0x2FFC: F_exc_adel=1. With D_rs_val=0x7000: F_exc_adel=1.
- req=1 together with eret=1 and stall=1, epc=0x3100 -> F_pc=0x4180, F_bd=0. Next cycle eret=1 alone -> F_pc=0x3100.
- reset asserted mid-stall with F_pc=0x3400 -> F_pc=0x3000 immediately, without waiting for a clock edge. With redirect_cnt at 16'hFFFF before the reset, one more taken jump leaves it at 16'hFFFF.

Source files
------------

// File: rtl/fetch_pc_unit_pkg.sv
// Shared fetch-address constants and next-PC helpers for the F stage.
// The address defaults are also used by CP0 and the instruction memory.
package fetch_pc_unit_pkg;

  localparam logic [31:0] DefResetPc  = 32'h0000_3000;
  localparam logic [31:0] DefExcEntry = 32'h0000_4180;
  localparam logic [31:0] DefImBase   = 32'h0000_3000;
  localparam logic [31:0] DefImLimit  = 32'h0000_6FFC;

  localparam logic [15:0] CntMax = 16'hFFFF;

  typedef enum logic [2:0] {
    NpcSeq,
    NpcHold,
    NpcExc,
    NpcEpc,
    NpcJr,
    NpcJ,
    NpcBranch
  } npc_sel_e;

  // Sign-extended word offset of a branch immediate.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
    return {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// D-stage control-transfer decode into the PC unit and F-stage status back out.
interface fetch_pc_unit_if;
  logic [31:0] D_pc;
  logic        D_is_branch;
  logic        D_cond;
  logic        D_is_j;
  logic [25:0] D_instr_index;
  logic [15:0] D_imm16;
  logic        D_is_jr;
  logic [31:0] D_rs_val;
  logic [31:0] F_pc;
  logic        F_bd;
  logic        F_exc_adel;

  modport master (
    output D_pc, D_is_branch, D_cond, D_is_j, D_instr_index, D_imm16, D_is_jr, D_rs_val,
    input  F_pc, F_bd, F_exc_adel
  );

  modport slave (
    input  D_pc, D_is_branch, D_cond, D_is_j, D_instr_index, D_imm16, D_is_jr, D_rs_val,
    output F_pc, F_bd, F_exc_adel
  );
endinterface

// File: rtl/fetch_pc_unit_npc_calc.sv
// Combinational target calculation: sequential, branch and j/jal addresses.
module fetch_pc_unit_npc_calc
  import fetch_pc_unit_pkg::*;
(
  input  logic [31:0] d_pc_i,
  input  logic [25:0] d_instr_index_i,
  input  logic [15:0] d_imm16_i,
  input  logic [31:0] f_pc_i,
  output logic [31:0] seq_pc_o,
  output logic [31:0] branch_pc_o,
  output logic [31:0] jump_pc_o
);

  logic [31:0] d_pc4;

  // Targets are relative to the delay slot, i.e. D_pc + 4; all math wraps mod 2^32.
  assign d_pc4       = d_pc_i + 32'd4;
  assign seq_pc_o    = f_pc_i + 32'd4;
  assign branch_pc_o = d_pc4 + branch_offset(d_imm16_i);
  assign jump_pc_o   = {d_pc4[31:28], d_instr_index_i, 2'b00};

endmodule

// File: rtl/fetch_pc_unit.sv
// F-stage program counter with delayed-branch next-PC selection, exception/eret
// redirection, delay-slot flag, fetch address check and a redirect counter.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DefResetPc,
  parameter logic [31:0] EXC_ENTRY = DefExcEntry,
  parameter logic [31:0] IM_BASE   = DefImBase,
  parameter logic [31:0] IM_LIMIT  = DefImLimit
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  req,
  input  logic                  eret,
  input  logic [31:0]           epc,
  fetch_pc_unit_if.slave        fd,
  output logic [15:0]           redirect_cnt
);

  logic [31:0] f_pc_q, f_pc_d;
  logic        f_bd_q, f_bd_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] seq_pc, branch_pc, jump_pc;
  logic        redirect;
  npc_sel_e    sel;

  fetch_pc_unit_npc_calc u_npc_calc (
    .d_pc_i          (fd.D_pc),
    .d_instr_index_i (fd.D_instr_index),
    .d_imm16_i       (fd.D_imm16),
    .f_pc_i          (f_pc_q),
    .seq_pc_o        (seq_pc),
    .branch_pc_o     (branch_pc),
    .jump_pc_o       (jump_pc)
  );

  // req beats eret beats stall; the stall is irrelevant once CP0 flushes.
  always_comb begin
    sel = NpcSeq;
    if (req)                                sel = NpcExc;
    else if (eret)                          sel = NpcEpc;
    else if (stall)                         sel = NpcHold;
    else if (fd.D_is_jr)                    sel = NpcJr;
    else if (fd.D_is_j)                     sel = NpcJ;
    else if (fd.D_is_branch && fd.D_cond)   sel = NpcBranch;
  end

  always_comb begin
    f_pc_d   = seq_pc;
    f_bd_d   = fd.D_is_branch | fd.D_is_j | fd.D_is_jr;
    redirect = 1'b1;
    unique case (sel)
      NpcExc:    begin f_pc_d = EXC_ENTRY;   f_bd_d = 1'b0; end
      NpcEpc:    begin f_pc_d = epc;         f_bd_d = 1'b0; end
      NpcHold:   begin f_pc_d = f_pc_q;      f_bd_d = f_bd_q; redirect = 1'b0; end
      NpcJr:     f_pc_d = fd.D_rs_val;
      NpcJ:      f_pc_d = jump_pc;
      NpcBranch: f_pc_d = branch_pc;
      default:   redirect = 1'b0;
    endcase
    cnt_d = (redirect && (cnt_q != CntMax)) ? cnt_q + 16'd1 : cnt_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      f_pc_q <= RESET_PC;
      f_bd_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      f_pc_q <= f_pc_d;
      f_bd_q <= f_bd_d;
      cnt_q  <= cnt_d;
    end
  end

  assign fd.F_pc       = f_pc_q;
  assign fd.F_bd       = f_bd_q;
  assign fd.F_exc_adel = (f_pc_q[1:0] != 2'b00) | (f_pc_q < IM_BASE) | (f_pc_q > IM_LIMIT);
  assign redirect_cnt  = cnt_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed self-checking bench for fetch_pc_unit.
module tb_fetch_pc_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        req;
  logic        eret;
  logic [31:0] epc;
  logic [15:0] redirect_cnt;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  fetch_pc_unit_if fd ();

  fetch_pc_unit dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .req          (req),
    .eret         (eret),
    .epc          (epc),
    .fd           (fd.slave),
    .redirect_cnt (redirect_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_d();
    fd.D_pc          = '0;
    fd.D_is_branch   = 1'b0;
    fd.D_cond        = 1'b0;
    fd.D_is_j        = 1'b0;
    fd.D_instr_index = '0;
    fd.D_imm16       = '0;
    fd.D_is_jr       = 1'b0;
    fd.D_rs_val      = '0;
  endtask

  initial begin
    reset = 1'b0;
    stall = 1'b0;
    req   = 1'b0;
    eret  = 1'b0;
    epc   = '0;
    clear_d();

    #12;
    check_eq("rst_pc", fd.F_pc, 32'h3000);
    check_eq("rst_bd", {31'd0, fd.F_bd}, 32'd0);
    check_eq("rst_adel", {31'd0, fd.F_exc_adel}, 32'd0);
    check_eq("rst_cnt", {16'd0, redirect_cnt}, 32'd0);
    reset = 1'b1;
    #1;
    check_eq("rel_pc", fd.F_pc, 32'h3000);

    step(); check_eq("seq_pc1", fd.F_pc, 32'h3004);
    step(); check_eq("seq_pc2", fd.F_pc, 32'h3008);
    step(); check_eq("seq_pc3", fd.F_pc, 32'h300C);
    check_eq("seq_bd", {31'd0, fd.F_bd}, 32'd0);
    check_eq("seq_adel", {31'd0, fd.F_exc_adel}, 32'd0);

    // Taken backward branch: 0x3008 + 4 - 8.
    fd.D_pc = 32'h3008; fd.D_is_branch = 1'b1; fd.D_cond = 1'b1; fd.D_imm16 = 16'hFFFE;
    step();
    check_eq("br_pc", fd.F_pc, 32'h3004);
    check_eq("br_bd", {31'd0, fd.F_bd}, 32'd1);
    check_eq("br_cnt", {16'd0, redirect_cnt}, 32'd1);

    fd.D_pc = 32'h3010; fd.D_cond = 1'b0;
    step();
    check_eq("nt_pc", fd.F_pc, 32'h3008);
    check_eq("nt_bd", {31'd0, fd.F_bd}, 32'd1);
    check_eq("nt_cnt", {16'd0, redirect_cnt}, 32'd1);

    // Stall with a taken branch pending must hold everything.
    stall = 1'b1; fd.D_cond = 1'b1;
    step(); step();
    check_eq("stall_pc", fd.F_pc, 32'h3008);
    check_eq("stall_bd", {31'd0, fd.F_bd}, 32'd1);
    check_eq("stall_cnt", {16'd0, redirect_cnt}, 32'd1);
    stall = 1'b0;
    clear_d();

    fd.D_is_jr = 1'b1; fd.D_rs_val = 32'h3001;
    step();
    check_eq("jr_pc", fd.F_pc, 32'h3001);
    check_eq("jr_adel_align", {31'd0, fd.F_exc_adel}, 32'd1);
    check_eq("jr_bd", {31'd0, fd.F_bd}, 32'd1);
    fd.D_rs_val = 32'h2FFC;
    step(); check_eq("jr_adel_low", {31'd0, fd.F_exc_adel}, 32'd1);
    fd.D_rs_val = 32'h7000;
    step(); check_eq("jr_adel_high", {31'd0, fd.F_exc_adel}, 32'd1);
    fd.D_rs_val = 32'h6FFC;
    step();
    check_eq("jr_limit_pc", fd.F_pc, 32'h6FFC);
    check_eq("jr_adel_limit", {31'd0, fd.F_exc_adel}, 32'd0);
    check_eq("jr_cnt", {16'd0, redirect_cnt}, 32'd5);
    clear_d();

    req = 1'b1; eret = 1'b1; stall = 1'b1; epc = 32'h3100;
    step();
    check_eq("req_pc", fd.F_pc, 32'h4180);
    check_eq("req_bd", {31'd0, fd.F_bd}, 32'd0);
    check_eq("req_cnt", {16'd0, redirect_cnt}, 32'd6);
    req = 1'b0; stall = 1'b0;
    step();
    check_eq("eret_pc", fd.F_pc, 32'h3100);
    check_eq("eret_bd", {31'd0, fd.F_bd}, 32'd0);
    check_eq("eret_cnt", {16'd0, redirect_cnt}, 32'd7);
    eret = 1'b0;
    step();
    check_eq("post_eret_pc", fd.F_pc, 32'h3104);

    // j keeps the upper nibble of D_pc + 4.
    fd.D_pc = 32'hF000_0000; fd.D_is_j = 1'b1; fd.D_instr_index = 26'h000_0D00;
    step();
    check_eq("j_hi_pc", fd.F_pc, 32'hF000_3400);
    check_eq("j_hi_adel", {31'd0, fd.F_exc_adel}, 32'd1);
    check_eq("j_hi_cnt", {16'd0, redirect_cnt}, 32'd8);

    fd.D_pc = 32'h3100;
    repeat (65535 - 8) step();
    check_eq("sat_pc", fd.F_pc, 32'h3400);
    check_eq("sat_cnt", {16'd0, redirect_cnt}, 32'hFFFF);
    step();
    check_eq("sat_hold_cnt", {16'd0, redirect_cnt}, 32'hFFFF);

    // Asynchronous reset in the middle of a stall.
    clear_d();
    stall = 1'b1;
    step();
    check_eq("pre_rst_pc", fd.F_pc, 32'h3400);
    #2;
    reset = 1'b0;
    #1;
    check_eq("async_rst_pc", fd.F_pc, 32'h3000);
    check_eq("async_rst_bd", {31'd0, fd.F_bd}, 32'd0);
    check_eq("async_rst_cnt", {16'd0, redirect_cnt}, 32'd0);
    #2;
    reset = 1'b1;
    stall = 1'b0;
    step();
    check_eq("post_rst_pc", fd.F_pc, 32'h3004);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
